mat_row_writer: RTL and testbench

Write-back end of the matrix coprocessor datapath. It accepts packed 40-bit result rows (five signed 8-bit elements each) from the row-operation units, such as negation, addition or scalar multiply, and buffers a full 5×5 result. It then serialises the 25 elements as byte writes to the matrix memory at a programmed base address, and signals completion to the control FSM.

---
 rtl/mat_row_writer.sv | 119 +++++++++++
 tb/tb_mat_row_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_row_writer.sv
// Write-back stage: buffers a ROWS x ROWS matrix of packed result rows, then
// streams it row-major as byte writes starting at a latched base address.
module mat_row_writer #(
  parameter int ROWS   = 5,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   row_valid,
  input  logic [ROWS*ELEM_W-1:0] row_data,
  output logic                   row_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [ELEM_W-1:0]      mem_wdata,
  output logic                   mem_we,
  output logic                   busy,
  output logic                   done
);
  localparam int RW = ROWS*ELEM_W;
  localparam int NB = ROWS*ROWS;
  localparam int CW = $clog2(ROWS);
  localparam int BW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                  state;
  logic [ROWS-1:0][RW-1:0] rbuf;
  logic [ADDR_W-1:0]       base_q;
  logic [CW-1:0]           row_cnt, r, c, nr, nc;
  logic [BW-1:0]           byte_cnt;
  logic [ELEM_W-1:0]       nxt_elem;
  logic                    xfer;

  assign xfer = (state == COLLECT) && row_valid && row_ready;

  // (r, c) tracks the element on the bus; (nr, nc) is the one to present next.
  always_comb begin
    nr = r;
    nc = c + CW'(1);
    if (c == CW'(ROWS-1)) begin
      nc = '0;
      nr = (r == CW'(ROWS-1)) ? '0 : r + CW'(1);
    end
    nxt_elem = rbuf[nr][RW-1-ELEM_W*int'(nc) -: ELEM_W];
  end

  always_ff @(posedge clk) begin
    if (xfer) rbuf[row_cnt] <= row_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      row_cnt   <= '0;
      byte_cnt  <= '0;
      r         <= '0;
      c         <= '0;
      row_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            row_cnt   <= '0;
            byte_cnt  <= '0;
            r         <= '0;
            c         <= '0;
            row_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (xfer) begin
            if (row_cnt == CW'(ROWS-1)) begin
              // Row 0 is already buffered, so byte 0 can go out right away.
              row_ready <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= base_q;
              mem_wdata <= rbuf[0][RW-1 -: ELEM_W];
              state     <= WRITE;
            end else begin
              row_cnt <= row_cnt + CW'(1);
            end
          end
        end
        WRITE: begin
          if (byte_cnt == BW'(NB-1)) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            byte_cnt  <= byte_cnt + BW'(1);
            r         <= nr;
            c         <= nc;
            mem_addr  <= base_q + ADDR_W'(byte_cnt) + ADDR_W'(1);
            mem_wdata <= nxt_elem;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_row_writer.sv
// Directed bench for mat_row_writer: timing, ordering, wrap, ignored inputs, reset.
module tb_mat_row_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic        row_valid = 1'b0;
  logic [39:0] row_data = '0;
  logic        row_ready, mem_we, busy, done;
  logic [8:0]  mem_addr;
  logic [7:0]  mem_wdata;

  mat_row_writer #(.ROWS(5), .ELEM_W(8), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] wa [64];
  logic [7:0] wd [64];
  int         wc [64];
  int         nwr = 0, done_cnt = 0, done_cyc = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      if (nwr < 64) begin wa[nwr] = mem_addr; wd[nwr] = mem_wdata; wc[nwr] = cyc; end
      nwr++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  logic [39:0] rows [5];
  bit          gp [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int          pass_cnt = 0, tot = 0, acc_cyc = 0;
  bit          pre_bad = 0;

  task automatic tick; @(negedge clk); #1; endtask

  task automatic clr; nwr = 0; done_cnt = 0; endtask

  task automatic load_basic;
    rows[0] = 40'h0102030405; rows[1] = 40'h060708090A; rows[2] = 40'h0B0C0D0E0F;
    rows[3] = 40'h1011121314; rows[4] = 40'h1516171819;
  endtask

  task automatic do_start(input logic [8:0] b);
    base_addr = b; start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic send_rows(input int k0, input int k1, input bit gaps);
    int k = k0, i = 0, g = 0;
    bit acc;
    pre_bad = 0;
    while (k < k1 && g < 200) begin
      row_valid = gaps ? gp[i % 9] : 1'b1;
      row_data  = rows[k];
      acc = row_valid && row_ready;
      if (nwr != 0) pre_bad = 1;
      tick;
      if (acc) k++;
      i++; g++;
    end
    row_valid = 1'b0; row_data = '0; acc_cyc = cyc;
    tot++; if (k != k1) $display("FAIL rows_accept got=%0d rows want=%0d", k - k0, k1 - k0); else pass_cnt++;
  endtask

  task automatic wait_done;
    int g = 0;
    while (done_cnt == 0 && g < 60) begin tick; g++; end
    tot++; if (done_cnt != 1) $display("FAIL done_seen got=%0d want=1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick;
    tot++;
    if ({row_ready, mem_we, busy, done, mem_addr, mem_wdata} !== 21'd0)
      $display("FAIL reset_outs got=%b want=0", {row_ready, mem_we, busy, done, mem_addr, mem_wdata});
    else pass_cnt++;
    rst = 1'b0; tick;
  endtask

  task automatic test_basic;
    clr; load_basic; do_start(9'h010);
    tot++; if ({busy, row_ready} !== 2'b11) $display("FAIL start_lat got=%b want=11", {busy, row_ready}); else pass_cnt++;
    send_rows(0, 5, 1'b0);
    tot++; if ({row_ready, mem_we} !== 2'b01) $display("FAIL first_wr got=%b want=01", {row_ready, mem_we}); else pass_cnt++;
    wait_done;
    tot++; if (done_cyc != acc_cyc + 25) $display("FAIL done_time got=%0d want=%0d", done_cyc, acc_cyc + 25); else pass_cnt++;
    tot++; if (nwr != 25) $display("FAIL basic_nwr got=%0d want=25", nwr); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      tot++;
      if (wa[i] !== 9'(16 + i) || wd[i] !== 8'(i + 1) || wc[i] != acc_cyc + i)
        $display("FAIL basic_wr[%0d] got=%h/%h@%0d want=%h/%h@%0d", i, wa[i], wd[i], wc[i], 9'(16 + i), 8'(i + 1), acc_cyc + i);
      else pass_cnt++;
    end
    tick;
    tot++; if ({busy, row_ready, done} !== 3'b000) $display("FAIL idle_after got=%b want=000", {busy, row_ready, done}); else pass_cnt++;
  endtask

  task automatic test_signed;
    logic [7:0] sx [5] = '{8'hFF, 8'h80, 8'h01, 8'h7F, 8'h00};
    clr; load_basic; rows[0] = 40'hFF80017F00;
    do_start(9'h040); send_rows(0, 5, 1'b0); wait_done;
    for (int i = 0; i < 5; i++) begin
      tot++;
      if (wa[i] !== 9'(64 + i) || wd[i] !== sx[i])
        $display("FAIL signed_wr[%0d] got=%h/%h want=%h/%h", i, wa[i], wd[i], 9'(64 + i), sx[i]);
      else pass_cnt++;
    end
    tot++; if (wd[5] !== 8'h06) $display("FAIL signed_row1 got=%h want=06", wd[5]); else pass_cnt++;
    tick;
  endtask

  task automatic test_gaps;
    clr; load_basic; do_start(9'h010); send_rows(0, 5, 1'b1);
    tot++; if (pre_bad) $display("FAIL gaps_early got=writes want=none"); else pass_cnt++;
    wait_done;
    tot++; if (nwr != 25) $display("FAIL gaps_nwr got=%0d want=25", nwr); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      tot++;
      if (wa[i] !== 9'(16 + i) || wd[i] !== 8'(i + 1))
        $display("FAIL gaps_wr[%0d] got=%h/%h want=%h/%h", i, wa[i], wd[i], 9'(16 + i), 8'(i + 1));
      else pass_cnt++;
    end
    tick;
  endtask

  task automatic test_wrap;
    clr; load_basic; do_start(9'h1F0); send_rows(0, 5, 1'b0); wait_done;
    tot++; if (nwr != 25) $display("FAIL wrap_nwr got=%0d want=25", nwr); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      tot++;
      if (wa[i] !== 9'(496 + i) || wd[i] !== 8'(i + 1))
        $display("FAIL wrap_wr[%0d] got=%h/%h want=%h/%h", i, wa[i], wd[i], 9'(496 + i), 8'(i + 1));
      else pass_cnt++;
    end
    tick;
  endtask

  task automatic test_ignored;
    clr; load_basic; do_start(9'h010);
    send_rows(0, 2, 1'b0);
    do_start(9'h100);
    send_rows(2, 5, 1'b0);
    row_valid = 1'b1; row_data = 40'hAAAAAAAAAA;
    repeat (10) tick;
    row_valid = 1'b0; row_data = '0;
    wait_done;
    repeat (5) tick;
    tot++; if (done_cnt != 1) $display("FAIL ign_done got=%0d want=1", done_cnt); else pass_cnt++;
    tot++; if (nwr != 25) $display("FAIL ign_nwr got=%0d want=25", nwr); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      tot++;
      if (wa[i] !== 9'(16 + i) || wd[i] !== 8'(i + 1))
        $display("FAIL ign_wr[%0d] got=%h/%h want=%h/%h", i, wa[i], wd[i], 9'(16 + i), 8'(i + 1));
      else pass_cnt++;
    end
  endtask

  task automatic test_rst_mid;
    int g = 0;
    clr; load_basic; do_start(9'h050); send_rows(0, 5, 1'b0);
    while (nwr < 11 && g < 40) begin tick; g++; end
    tot++; if (wa[10] !== 9'h05A) $display("FAIL rst_byte10 got=%h want=05a", wa[10]); else pass_cnt++;
    rst = 1'b1; tick; rst = 1'b0;
    tot++;
    if ({mem_we, busy, done, row_ready, mem_addr, mem_wdata} !== 21'd0)
      $display("FAIL rst_outs got=%b want=0", {mem_we, busy, done, row_ready, mem_addr, mem_wdata});
    else pass_cnt++;
    repeat (30) tick;
    tot++; if (done_cnt != 0 || nwr != 11) $display("FAIL rst_abandon got=done%0d/wr%0d want=done0/wr11", done_cnt, nwr); else pass_cnt++;
    clr; do_start(9'h010); send_rows(0, 5, 1'b0); wait_done;
    tot++; if (nwr != 25) $display("FAIL rst_fresh_nwr got=%0d want=25", nwr); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      tot++;
      if (wa[i] !== 9'(16 + i) || wd[i] !== 8'(i + 1))
        $display("FAIL rst_fresh_wr[%0d] got=%h/%h want=%h/%h", i, wa[i], wd[i], 9'(16 + i), 8'(i + 1));
      else pass_cnt++;
    end
    tick;
  endtask

  task automatic test_back_to_back;
    clr; load_basic; do_start(9'h030); send_rows(0, 5, 1'b0); wait_done;
    tick;
    tot++; if (busy !== 1'b0) $display("FAIL b2b_fall got=%b want=0", busy); else pass_cnt++;
    clr; do_start(9'h0A0);
    tot++; if ({busy, row_ready} !== 2'b11) $display("FAIL b2b_start got=%b want=11", {busy, row_ready}); else pass_cnt++;
    send_rows(0, 5, 1'b0); wait_done;
    tot++; if (nwr != 25) $display("FAIL b2b_nwr got=%0d want=25", nwr); else pass_cnt++;
    tot++;
    if (wa[0] !== 9'h0A0 || wa[24] !== 9'h0B8 || wd[24] !== 8'h19)
      $display("FAIL b2b_wr got=%h..%h/%h want=0a0..0b8/19", wa[0], wa[24], wd[24]);
    else pass_cnt++;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_gaps;
    test_wrap;
    test_ignored;
    test_rst_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=hang want=finish");
    $fatal(1);
  end
endmodule
